// File: rtl/taylor_axil_regbank_if.sv
// AXI4-Lite bus bundle between the interconnect and the Taylor register bank.
interface taylor_axil_regbank_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/taylor_axil_regbank.sv
// AXI4-Lite register bank for the Taylor core: CTRL/STATUS/ARG/RESULT plus scratch,
// byte strobes, independent AW/W acceptance and a start/done handshake with interrupt.
module taylor_axil_regbank #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    taylor_axil_regbank_if.slave  s_axi,
    output logic                  core_start,
    output logic [DATA_WIDTH-1:0] core_arg,
    input  logic                  core_done,
    input  logic [DATA_WIDTH-1:0] core_result,
    output logic                  irq
);
    localparam int unsigned STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB = $clog2(STRB_W);
    localparam int unsigned IDX_W    = ADDR_WIDTH - ADDR_LSB;

    localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ARG    = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_RESULT = IDX_W'(3);
    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;

    // AXI channel state
    logic                  r_awready, r_wready, r_arready;
    logic                  r_aw_pending, r_w_pending, r_ar_pending;
    logic [IDX_W-1:0]      r_aw_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic                  r_bvalid, r_rvalid;
    logic [1:0]            r_bresp, r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata, r_rd_buf;
    logic                  r_rd_err;

    // Register file and core handshake state
    logic                  r_irq_en, r_busy, r_done, r_overrun;
    logic [DATA_WIDTH-1:0] r_arg, r_result;
    logic [DATA_WIDTH-1:0] r_scratch [4:NUM_REGS-1];
    logic                  r_core_start, r_irq;

    logic                  w_aw_fire, w_w_fire, w_ar_fire, w_commit;
    logic                  w_aw_pending_nxt, w_w_pending_nxt, w_bvalid_nxt, w_rvalid_nxt;
    logic                  w_wr_err, w_start_req, w_start_ok, w_overrun_set;
    logic                  w_sts_wr, w_clr_done, w_clr_ovr;
    logic [IDX_W-1:0]      w_ar_idx;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_rd_err;

    function automatic logic [DATA_WIDTH-1:0] f_merge(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] new_val,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_val;
        for (int b = 0; b < int'(STRB_W); b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    // Handshake bookkeeping; a write commits once both halves sit in their latches
    always_comb begin
        w_aw_fire        = s_axi.awvalid && r_awready;
        w_w_fire         = s_axi.wvalid && r_wready;
        w_ar_fire        = s_axi.arvalid && r_arready;
        w_commit         = r_aw_pending && r_w_pending;
        w_aw_pending_nxt = !w_commit && (r_aw_pending || w_aw_fire);
        w_w_pending_nxt  = !w_commit && (r_w_pending || w_w_fire);
        w_bvalid_nxt     = w_commit || (r_bvalid && !s_axi.bready);
        w_rvalid_nxt     = r_ar_pending || (r_rvalid && !s_axi.rready);
    end

    // Write decode, start/overrun arbitration and W1C strobes
    always_comb begin
        w_wr_err      = ({1'b0, r_aw_idx} >= (IDX_W + 1)'(NUM_REGS)) || (r_aw_idx == IDX_RESULT);
        w_start_req   = w_commit && (r_aw_idx == IDX_CTRL) && r_wstrb[0] && r_wdata[0];
        w_start_ok    = w_start_req && !r_busy;
        w_overrun_set = w_start_req && r_busy;
        w_sts_wr      = w_commit && (r_aw_idx == IDX_STATUS) && r_wstrb[0];
        w_clr_done    = w_sts_wr && r_wdata[1];
        w_clr_ovr     = w_sts_wr && r_wdata[2];
    end

    // Read mux, evaluated on the live address so the acceptance edge samples it
    always_comb begin
        w_ar_idx  = s_axi.araddr[ADDR_WIDTH-1:ADDR_LSB];
        w_rd_data = '0;
        w_rd_err  = 1'b0;
        if ({1'b0, w_ar_idx} >= (IDX_W + 1)'(NUM_REGS)) begin
            w_rd_err = 1'b1;
        end else begin
            case (w_ar_idx)
                IDX_CTRL:   w_rd_data = DATA_WIDTH'({r_irq_en, 1'b0});
                IDX_STATUS: w_rd_data = DATA_WIDTH'({r_overrun, r_done, r_busy});
                IDX_ARG:    w_rd_data = r_arg;
                IDX_RESULT: w_rd_data = r_result;
                default: begin
                    for (int i = 4; i < int'(NUM_REGS); i++) begin
                        if (w_ar_idx == IDX_W'(i)) w_rd_data = r_scratch[i];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_awready    <= 1'b0;
            r_wready     <= 1'b0;
            r_arready    <= 1'b0;
            r_aw_pending <= 1'b0;
            r_w_pending  <= 1'b0;
            r_ar_pending <= 1'b0;
            r_aw_idx     <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_bvalid     <= 1'b0;
            r_rvalid     <= 1'b0;
            r_bresp      <= RESP_OKAY;
            r_rresp      <= RESP_OKAY;
            r_rdata      <= '0;
            r_rd_buf     <= '0;
            r_rd_err     <= 1'b0;
            r_irq_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
            r_arg        <= '0;
            r_result     <= '0;
            for (int i = 4; i < int'(NUM_REGS); i++) r_scratch[i] <= '0;
            r_core_start <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            r_aw_pending <= w_aw_pending_nxt;
            r_w_pending  <= w_w_pending_nxt;
            r_bvalid     <= w_bvalid_nxt;
            r_awready    <= !w_aw_pending_nxt && !w_bvalid_nxt;
            r_wready     <= !w_w_pending_nxt && !w_bvalid_nxt;
            if (w_aw_fire) r_aw_idx <= s_axi.awaddr[ADDR_WIDTH-1:ADDR_LSB];
            if (w_w_fire) begin
                r_wdata <= s_axi.wdata;
                r_wstrb <= s_axi.wstrb;
            end
            if (w_commit) r_bresp <= w_wr_err ? RESP_SLVERR : RESP_OKAY;

            // Read: capture at acceptance, present one edge later, hold until rready
            r_ar_pending <= w_ar_fire;
            r_rvalid     <= w_rvalid_nxt;
            r_arready    <= !w_ar_fire && !w_rvalid_nxt;
            if (w_ar_fire) begin
                r_rd_buf <= w_rd_data;
                r_rd_err <= w_rd_err;
            end
            if (r_ar_pending) begin
                r_rdata <= r_rd_buf;
                r_rresp <= r_rd_err ? RESP_SLVERR : RESP_OKAY;
            end

            if (w_commit && !w_wr_err) begin
                case (r_aw_idx)
                    IDX_CTRL:   if (r_wstrb[0]) r_irq_en <= r_wdata[1];
                    IDX_STATUS: ;
                    IDX_ARG:    r_arg <= f_merge(r_arg, r_wdata, r_wstrb);
                    IDX_RESULT: ;
                    default: begin
                        for (int i = 4; i < int'(NUM_REGS); i++) begin
                            if (r_aw_idx == IDX_W'(i))
                                r_scratch[i] <= f_merge(r_scratch[i], r_wdata, r_wstrb);
                        end
                    end
                endcase
            end

            // Core handshake: BUSY is judged before a same-cycle done; sticky set beats W1C
            r_core_start <= w_start_ok;
            if (w_start_ok)     r_busy <= 1'b1;
            else if (core_done) r_busy <= 1'b0;
            if (core_done)       r_done <= 1'b1;
            else if (w_clr_done) r_done <= 1'b0;
            if (w_overrun_set)  r_overrun <= 1'b1;
            else if (w_clr_ovr) r_overrun <= 1'b0;
            if (core_done) r_result <= core_result;
            r_irq <= r_irq_en && r_done;
        end
    end

    assign s_axi.awready = r_awready;
    assign s_axi.wready  = r_wready;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bresp   = r_bresp;
    assign s_axi.arready = r_arready;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = r_rresp;
    assign core_start    = r_core_start;
    assign core_arg      = r_arg;
    assign irq           = r_irq;
endmodule

// File: tb/tb_taylor_axil_regbank.sv
// Directed bench for taylor_axil_regbank: 32-bit main instance plus a 64-bit instance.
module tb_taylor_axil_regbank;
    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    always #5 ACLK = ~ACLK;

    taylor_axil_regbank_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) axi ();
    taylor_axil_regbank_if #(.ADDR_WIDTH(8), .DATA_WIDTH(64)) axi64 ();

    logic        core_start, core_done, irq;
    logic [31:0] core_arg, core_result;
    logic        core_start64, core_done64, irq64;
    logic [63:0] core_arg64, core_result64;

    taylor_axil_regbank #(.DATA_WIDTH(32), .NUM_REGS(8), .ADDR_WIDTH(8)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(axi.slave),
        .core_start(core_start), .core_arg(core_arg), .core_done(core_done),
        .core_result(core_result), .irq(irq)
    );

    taylor_axil_regbank #(.DATA_WIDTH(64), .NUM_REGS(8), .ADDR_WIDTH(8)) dut64 (
        .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(axi64.slave),
        .core_start(core_start64), .core_arg(core_arg64), .core_done(core_done64),
        .core_result(core_result64), .irq(irq64)
    );

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int b_hs = 0;

    always @(negedge ACLK) begin
        if (core_start) start_cnt++;
        if (axi.bvalid && axi.bready) b_hs++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // W may lead AW by w_lead cycles; bready is withheld b_delay cycles after bvalid
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int w_lead, input int b_delay, output logic [1:0] resp);
        logic aw_done, w_done, aw_hs, w_hs;
        int cyc;
        axi.awaddr = addr; axi.wdata = data; axi.wstrb = strb;
        axi.wvalid = 1'b1; axi.awvalid = (w_lead == 0);
        aw_done = 1'b0; w_done = 1'b0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 50) begin
            aw_hs = axi.awvalid && axi.awready;
            w_hs  = axi.wvalid && axi.wready;
            tick(); cyc++;
            if (aw_hs) begin axi.awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs) begin axi.wvalid = 1'b0; w_done = 1'b1; end
            if (!aw_done && !axi.awvalid && cyc >= w_lead) axi.awvalid = 1'b1;
        end
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        check("aw_w_accept_timeout", 64'(cyc >= 50), 0);
        cyc = 0;
        while (!axi.bvalid && cyc < 50) begin tick(); cyc++; end
        check("bvalid_timeout", 64'(cyc >= 50), 0);
        if (b_delay > 0) begin
            repeat (b_delay) tick();
            check("bvalid_held", 64'(axi.bvalid), 1);
            check("awready_blocked", 64'(axi.awready), 0);
            check("wready_blocked", 64'(axi.wready), 0);
        end
        resp = axi.bresp;
        axi.bready = 1'b1; tick(); axi.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, input int r_delay,
                            output logic [31:0] data, output logic [1:0] resp);
        int cyc;
        logic hs;
        axi.araddr = addr; axi.arvalid = 1'b1; cyc = 0; hs = 1'b0;
        while (!hs && cyc < 50) begin
            hs = axi.arvalid && axi.arready;
            tick(); cyc++;
        end
        axi.arvalid = 1'b0;
        check("ar_accept_timeout", 64'(hs), 1);
        cyc = 0;
        while (!axi.rvalid && cyc < 50) begin tick(); cyc++; end
        check("rvalid_timeout", 64'(cyc >= 50), 0);
        if (r_delay > 0) begin
            repeat (r_delay) tick();
            check("rvalid_held", 64'(axi.rvalid), 1);
            check("arready_blocked", 64'(axi.arready), 0);
        end
        data = axi.rdata; resp = axi.rresp;
        axi.rready = 1'b1; tick(); axi.rready = 1'b0;
    endtask

    task automatic wr_ok(input logic [7:0] addr, input logic [31:0] data);
        logic [1:0] resp;
        axi_write(addr, data, 4'hF, 0, 0, resp);
        check("write_resp_okay", 64'(resp), 0);
    endtask

    task automatic rd_exp(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] data;
        logic [1:0]  resp;
        axi_read(addr, 0, data, resp);
        check(tag, 64'(data), 64'(exp));
        check("read_resp_okay", 64'(resp), 0);
    endtask

    task automatic pulse_done(input logic [31:0] result);
        core_result = result; core_done = 1'b1;
        tick();
        core_done = 1'b0;
    endtask

    task automatic axi64_write(input logic [7:0] addr, input logic [63:0] data, output logic [1:0] resp);
        int cyc;
        axi64.awaddr = addr; axi64.wdata = data; axi64.wstrb = 8'hFF;
        axi64.awvalid = 1'b1; axi64.wvalid = 1'b1;
        tick();
        axi64.awvalid = 1'b0; axi64.wvalid = 1'b0;
        cyc = 0;
        while (!axi64.bvalid && cyc < 50) begin tick(); cyc++; end
        check("b64_timeout", 64'(cyc >= 50), 0);
        resp = axi64.bresp;
        axi64.bready = 1'b1; tick(); axi64.bready = 1'b0;
    endtask

    task automatic axi64_read(input logic [7:0] addr, output logic [63:0] data, output logic [1:0] resp);
        int cyc;
        axi64.araddr = addr; axi64.arvalid = 1'b1;
        tick();
        axi64.arvalid = 1'b0;
        cyc = 0;
        while (!axi64.rvalid && cyc < 50) begin tick(); cyc++; end
        check("r64_timeout", 64'(cyc >= 50), 0);
        data = axi64.rdata; resp = axi64.rresp;
        axi64.rready = 1'b1; tick(); axi64.rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [63:0] d64;
        logic [1:0]  resp;
        int          s0, b0;

        axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 0; axi.wdata = '0; axi.wstrb = '0;
        axi.wvalid = 0; axi.bready = 0; axi.araddr = '0; axi.arprot = '0; axi.arvalid = 0; axi.rready = 0;
        axi64.awaddr = '0; axi64.awprot = '0; axi64.awvalid = 0; axi64.wdata = '0; axi64.wstrb = '0;
        axi64.wvalid = 0; axi64.bready = 0; axi64.araddr = '0; axi64.arprot = '0; axi64.arvalid = 0;
        axi64.rready = 0;
        core_done = 0; core_result = '0; core_done64 = 0; core_result64 = '0;

        // Reset state
        repeat (3) tick();
        check("rst_awready", 64'(axi.awready), 0);
        check("rst_wready", 64'(axi.wready), 0);
        check("rst_arready", 64'(axi.arready), 0);
        check("rst_bvalid", 64'(axi.bvalid), 0);
        check("rst_rvalid", 64'(axi.rvalid), 0);
        check("rst_rdata", 64'(axi.rdata), 0);
        check("rst_core_start", 64'(core_start), 0);
        check("rst_irq", 64'(irq), 0);
        ARESETN = 1'b1;
        check("release_awready_low", 64'(axi.awready), 0);
        tick();
        check("ready_aw_after_edge", 64'(axi.awready), 1);
        check("ready_w_after_edge", 64'(axi.wready), 1);
        check("ready_ar_after_edge", 64'(axi.arready), 1);

        // Scratch write/readback
        for (int i = 0; i < 4; i++) wr_ok(8'(16 + 4 * i), 32'(i + 1));
        for (int i = 0; i < 4; i++) rd_exp("scratch_readback", 8'(16 + 4 * i), 32'(i + 1));

        // Strobes with W leading AW by 3 cycles
        b0 = b_hs;
        axi_write(8'h08, 32'hAABBCCDD, 4'b0101, 3, 0, resp);
        check("strobe_bresp", 64'(resp), 0);
        repeat (3) tick();
        check("strobe_single_bvalid", 64'(b_hs - b0), 1);
        check("strobe_bvalid_clear", 64'(axi.bvalid), 0);
        rd_exp("arg_strobed", 8'h08, 32'h00BB00DD);
        check("core_arg_out", 64'(core_arg), 'h00BB00DD);

        // Compute handshake
        s0 = start_cnt;
        wr_ok(8'h00, 32'h3);
        check("start_one_pulse", 64'(start_cnt - s0), 1);
        rd_exp("status_busy", 8'h04, 32'h1);
        rd_exp("ctrl_start_reads0", 8'h00, 32'h2);
        pulse_done(32'h3F800000);
        check("irq_lag", 64'(irq), 0);
        tick();
        check("irq_set", 64'(irq), 1);
        rd_exp("result_captured", 8'h0C, 32'h3F800000);
        rd_exp("status_done", 8'h04, 32'h2);
        wr_ok(8'h04, 32'h2);
        check("irq_cleared", 64'(irq), 0);
        rd_exp("status_cleared", 8'h04, 32'h0);

        // Overrun
        s0 = start_cnt;
        wr_ok(8'h00, 32'h3);
        wr_ok(8'h00, 32'h3);
        repeat (2) tick();
        check("overrun_no_pulse", 64'(start_cnt - s0), 1);
        rd_exp("status_overrun", 8'h04, 32'h5);
        pulse_done(32'h12345678);
        rd_exp("status_done_ovr", 8'h04, 32'h6);
        wr_ok(8'h04, 32'h6);
        rd_exp("status_w1c_both", 8'h04, 32'h0);

        // Error paths
        axi_write(8'h0C, 32'hFFFFFFFF, 4'hF, 0, 0, resp);
        check("result_write_slverr", 64'(resp), 2);
        rd_exp("result_unchanged", 8'h0C, 32'h12345678);
        axi_read(8'h20, 0, d, resp);
        check("oor_rdata", 64'(d), 0);
        check("oor_rresp", 64'(resp), 2);
        axi_write(8'h3C, 32'h1, 4'hF, 0, 0, resp);
        check("oor_write_slverr", 64'(resp), 2);

        // Backpressure on B and R
        axi_write(8'h14, 32'hCAFEF00D, 4'hF, 0, 5, resp);
        check("bp_bresp", 64'(resp), 0);
        axi_read(8'h14, 5, d, resp);
        check("bp_rdata", 64'(d), 'hCAFEF00D);
        check("bp_rresp", 64'(resp), 0);

        // core_done coincident with DONE W1C: set wins
        pulse_done(32'h1);
        rd_exp("stray_done_result", 8'h0C, 32'h1);
        axi.awaddr = 8'h04; axi.wdata = 32'h2; axi.wstrb = 4'hF;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        tick();
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        core_result = 32'h55; core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("coinc_bvalid", 64'(axi.bvalid), 1);
        check("coinc_bresp", 64'(axi.bresp), 0);
        axi.bready = 1'b1; tick(); axi.bready = 1'b0;
        rd_exp("coinc_done_wins", 8'h04, 32'h2);
        rd_exp("coinc_result", 8'h0C, 32'h55);

        // Reset with AW pending; core_done during reset is ignored
        axi.awaddr = 8'h18; axi.awvalid = 1'b1;
        tick();
        axi.awvalid = 1'b0;
        ARESETN = 1'b0;
        core_result = 32'hFFFF; core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        ARESETN = 1'b1;
        b0 = b_hs;
        repeat (4) tick();
        check("rst_mid_no_bvalid", 64'(axi.bvalid), 0);
        check("rst_mid_no_bhs", 64'(b_hs - b0), 0);
        check("rst_mid_core_arg", 64'(core_arg), 0);
        for (int i = 0; i < 8; i++) begin
            axi_read(8'(4 * i), 0, d, resp);
            check("rst_mid_reg_zero", 64'(d), 0);
        end
        wr_ok(8'h1C, 32'h77);
        rd_exp("post_rst_write", 8'h1C, 32'h77);
        rd_exp("post_rst_stale_aw", 8'h18, 32'h0);

        // 64-bit instance at 8-byte stride
        for (int i = 0; i < 4; i++) begin
            axi64_write(8'(32 + 8 * i), 64'(i + 1), resp);
            check("w64_resp", 64'(resp), 0);
        end
        for (int i = 0; i < 4; i++) begin
            axi64_read(8'(32 + 8 * i), d64, resp);
            check("r64_data", d64, 64'(i + 1));
            check("r64_resp", 64'(resp), 0);
        end
        axi64_write(8'h10, 64'hDEADBEEF_01234567, resp);
        axi64_read(8'h10, d64, resp);
        check("r64_arg_full", d64, 64'hDEADBEEF_01234567);
        axi64_read(8'h40, d64, resp);
        check("r64_oor_data", d64, 0);
        check("r64_oor_resp", 64'(resp), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
